alu_share_arbiter: RTL

- Shares one multi-cycle ALU between two requesters (port 0, port 1).
- Arbitrates round-robin and selects operands through a 2:1 data mux.
- Issues one operation at a time to the ALU, then routes the result back to the granted requester with a valid/ready handshake.
- Sits between the requester front-ends and the ALU core in the ALU datapath.

---
 rtl/alu_arb_pkg.sv | 14 +
 rtl/mux_2to1.sv | 13 +
 rtl/rr_arb2.sv | 14 +
 rtl/alu_share_arbiter.sv | 149 ++++++++++++++
 4 files changed

// File: rtl/alu_arb_pkg.sv
// rtl/alu_arb_pkg.sv - shared types and defaults for the ALU share arbiter
package alu_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } arb_state_e;

  localparam int DEF_OP_WIDTH       = 4;
  localparam int DEF_TIMEOUT_CYCLES = 64;

endpackage

// File: rtl/mux_2to1.sv
// rtl/mux_2to1.sv - parameterised 2:1 data mux
module mux_2to1 #(
  parameter int W = 32
) (
  input  logic [W-1:0] d0_i,
  input  logic [W-1:0] d1_i,
  input  logic         s_i,
  output logic [W-1:0] y_o
);

  assign y_o = s_i ? d1_i : d0_i;

endmodule

// File: rtl/rr_arb2.sv
// rtl/rr_arb2.sv - two-request round-robin winner select (combinational)
module rr_arb2 (
  input  logic [1:0] req_i,
  input  logic       grant_id_i,
  output logic       any_o,
  output logic       winner_o
);

  assign any_o = |req_i;

  // Under contention the port that did not win last time goes next.
  assign winner_o = (req_i == 2'b11) ? ~grant_id_i : req_i[1];

endmodule

// File: rtl/alu_share_arbiter.sv
// rtl/alu_share_arbiter.sv - shares one multi-cycle ALU between two requesters
// Optional WAIT watchdog with error response: define ALU_ARB_TIMEOUT_EN.
module alu_share_arbiter
  import alu_arb_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int OP_WIDTH       = DEF_OP_WIDTH,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [1:0]            req_valid,
  output logic [1:0]            req_ready,
  input  logic [DATA_WIDTH-1:0] req_a0,
  input  logic [DATA_WIDTH-1:0] req_b0,
  input  logic [DATA_WIDTH-1:0] req_a1,
  input  logic [DATA_WIDTH-1:0] req_b1,
  input  logic [OP_WIDTH-1:0]   req_op0,
  input  logic [OP_WIDTH-1:0]   req_op1,
  output logic                  alu_start,
  output logic [DATA_WIDTH-1:0] alu_a,
  output logic [DATA_WIDTH-1:0] alu_b,
  output logic [OP_WIDTH-1:0]   alu_op,
  input  logic                  alu_done,
  input  logic [DATA_WIDTH-1:0] alu_result,
  output logic [1:0]            rsp_valid,
  input  logic [1:0]            rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_data,
  output logic                  rsp_err,
  output logic                  grant_id
);

  arb_state_e            state_q;
  logic                  grant_q;
  logic                  alu_start_q;
  logic [DATA_WIDTH-1:0] alu_a_q;
  logic [DATA_WIDTH-1:0] alu_b_q;
  logic [OP_WIDTH-1:0]   alu_op_q;
  logic [1:0]            rsp_valid_q;
  logic [DATA_WIDTH-1:0] rsp_data_q;

  logic                  any_req;
  logic                  winner;
  logic [DATA_WIDTH-1:0] sel_a;
  logic [DATA_WIDTH-1:0] sel_b;
  logic [OP_WIDTH-1:0]   sel_op;

`ifdef ALU_ARB_TIMEOUT_EN
  localparam int TMO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);
  logic [TMO_W-1:0] tmo_cnt_q;
  logic             rsp_err_q;
  assign rsp_err = rsp_err_q;
`else
  assign rsp_err = 1'b0;
`endif

  rr_arb2 u_rr_arb2 (
    .req_i      (req_valid),
    .grant_id_i (grant_q),
    .any_o      (any_req),
    .winner_o   (winner)
  );

  mux_2to1 #(.W(DATA_WIDTH)) u_mux_a (.d0_i(req_a0),  .d1_i(req_a1),  .s_i(winner), .y_o(sel_a));
  mux_2to1 #(.W(DATA_WIDTH)) u_mux_b (.d0_i(req_b0),  .d1_i(req_b1),  .s_i(winner), .y_o(sel_b));
  mux_2to1 #(.W(OP_WIDTH))   u_mux_op(.d0_i(req_op0), .d1_i(req_op1), .s_i(winner), .y_o(sel_op));

  // Accept is combinational so the winner sees ready in the cycle it is chosen.
  always_comb begin
    req_ready = 2'b00;
    if (rst_n && (state_q == ST_IDLE) && any_req) begin
      req_ready = winner ? 2'b10 : 2'b01;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      grant_q     <= 1'b1;
      alu_start_q <= 1'b0;
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      alu_op_q    <= '0;
      rsp_valid_q <= 2'b00;
      rsp_data_q  <= '0;
`ifdef ALU_ARB_TIMEOUT_EN
      tmo_cnt_q   <= '0;
      rsp_err_q   <= 1'b0;
`endif
    end else begin
      alu_start_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (any_req) begin
            alu_a_q     <= sel_a;
            alu_b_q     <= sel_b;
            alu_op_q    <= sel_op;
            grant_q     <= winner;
            alu_start_q <= 1'b1;
            state_q     <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
`ifdef ALU_ARB_TIMEOUT_EN
          tmo_cnt_q <= '0;
`endif
          state_q <= ST_WAIT;
        end
        ST_WAIT: begin
          if (alu_done) begin
            rsp_data_q  <= alu_result;
            rsp_valid_q <= grant_q ? 2'b10 : 2'b01;
            state_q     <= ST_RESP;
`ifdef ALU_ARB_TIMEOUT_EN
            rsp_err_q   <= 1'b0;
          end else if (tmo_cnt_q == TMO_LAST) begin
            rsp_data_q  <= '0;
            rsp_err_q   <= 1'b1;
            rsp_valid_q <= grant_q ? 2'b10 : 2'b01;
            state_q     <= ST_RESP;
          end else begin
            tmo_cnt_q <= tmo_cnt_q + 1'b1;
`endif
          end
        end
        ST_RESP: begin
          if (rsp_ready[grant_q]) begin
            rsp_valid_q <= 2'b00;
`ifdef ALU_ARB_TIMEOUT_EN
            rsp_err_q   <= 1'b0;
`endif
            state_q     <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign alu_start = alu_start_q;
  assign alu_a     = alu_a_q;
  assign alu_b     = alu_b_q;
  assign alu_op    = alu_op_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign grant_id  = grant_q;

endmodule
